// File: rtl/bram_rdr_pkg.sv
// bram_rdr_pkg: shared constants and state codes for the BRAM word reader.
// Optional build macro used by this slice: BRAM_RDR_PARITY_EN.
package bram_rdr_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DEPTH  = 32768;
    localparam int DEF_WORD_W = 8;
    localparam int DEF_CNT_W  = 12;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/bram_word_reader_if.sv
// bram_word_reader_if: request, memory-read and output-stream signals.
// BRAM_RDR_PARITY_EN adds out_parity alongside out_data.
interface bram_word_reader_if
    import bram_rdr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
)();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [CNT_W-1:0]  req_words;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_dout;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
`ifdef BRAM_RDR_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        input  req_valid,
        input  req_addr,
        input  req_words,
        input  mem_dout,
        input  out_ready,
        output req_ready,
        output mem_raddr,
        output out_valid,
        output out_data,
        output out_last,
`ifdef BRAM_RDR_PARITY_EN
        output out_parity,
`endif
        output busy
    );

    modport slave (
        output req_valid,
        output req_addr,
        output req_words,
        output mem_dout,
        output out_ready,
        input  req_ready,
        input  mem_raddr,
        input  out_valid,
        input  out_data,
        input  out_last,
`ifdef BRAM_RDR_PARITY_EN
        input  out_parity,
`endif
        input  busy
    );

endinterface

// File: rtl/bram_rdr_packer.sv
// bram_rdr_packer: packs captured bits LSB-first into words on a valid/ready output.
// BRAM_RDR_PARITY_EN adds a registered even-parity bit for each word.
module bram_rdr_packer
    import bram_rdr_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_v,
    input  logic              cap_bit,
    input  logic              cap_last,
    input  logic              out_ready,
    output logic              last_ok,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
`ifdef BRAM_RDR_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic              wrd_end;

    // the closing bit of a word may only be fetched if the output slot frees up
    assign last_ok = !(out_valid && !out_ready);
    assign wrd_end = cap_v && (bit_idx == IDX_W'(WORD_W - 1));

    // assembly value with the bit arriving this cycle merged in
    always_comb begin
        nxt          = asm_q;
        nxt[bit_idx] = cap_bit;
    end

    // bit assembly and output register; a completed word wins over a handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q      <= '0;
            bit_idx    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
`ifdef BRAM_RDR_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (cap_v) begin
                if (wrd_end) begin
                    out_data   <= nxt;
                    out_last   <= cap_last;
                    out_valid  <= 1'b1;
`ifdef BRAM_RDR_PARITY_EN
                    out_parity <= ^nxt;
`endif
                    asm_q      <= '0;
                    bit_idx    <= '0;
                end else begin
                    asm_q      <= nxt;
                    bit_idx    <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_word_reader.sv
// bram_word_reader: sweeps a 1-bit BRAM and streams the contents as packed words.
// BRAM_RDR_PARITY_EN adds out_parity on the output stream.
module bram_word_reader
    import bram_rdr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic               clk,
    input  logic               reset,
    bram_word_reader_if.master bus
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam int TOT_W = CNT_W + $clog2(WORD_W);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [TOT_W-1:0]  rem;
    logic [IDX_W-1:0]  iss_pos;
    logic              iss_v;
    logic              iss_last;
    logic              issue;
    logic              done_rx;
    logic              last_ok;
    logic [TOT_W-1:0]  total;

    logic              pk_valid;
    logic [WORD_W-1:0] pk_data;
    logic              pk_last;
`ifdef BRAM_RDR_PARITY_EN
    logic              pk_parity;
`endif

    assign total   = TOT_W'(bus.req_words) * TOT_W'(WORD_W);
    assign issue   = (state == RUN) && (rem != '0)
                   && ((iss_pos != IDX_W'(WORD_W - 1)) || last_ok);
    assign done_rx = pk_valid && bus.out_ready && pk_last;

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_raddr = addr;
    assign bus.out_valid = pk_valid;
    assign bus.out_data  = pk_data;
    assign bus.out_last  = pk_last;
`ifdef BRAM_RDR_PARITY_EN
    assign bus.out_parity = pk_parity;
`endif

    // burst FSM, wrapping read address, bits-left counter and read-in-flight flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            iss_pos  <= '0;
            iss_v    <= 1'b0;
            iss_last <= 1'b0;
        end else begin
            iss_v    <= issue;
            iss_last <= issue && (rem == TOT_W'(1));
            if (issue) begin
                addr    <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
                rem     <= rem - 1'b1;
                iss_pos <= (iss_pos == IDX_W'(WORD_W - 1)) ? '0 : iss_pos + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_words != '0) begin
                        addr    <= bus.req_addr;
                        rem     <= total;
                        iss_pos <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (rem == '0 && !iss_v)
                        state <= done_rx ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (done_rx)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bram_rdr_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .cap_v      (iss_v),
        .cap_bit    (bus.mem_dout),
        .cap_last   (iss_last),
        .out_ready  (bus.out_ready),
        .last_ok    (last_ok),
        .out_valid  (pk_valid),
        .out_data   (pk_data),
        .out_last   (pk_last)
`ifdef BRAM_RDR_PARITY_EN
        ,
        .out_parity (pk_parity)
`endif
    );

endmodule

// File: tb/tb_bram_word_reader.sv
// tb_bram_word_reader: random and directed bursts against a bit-array memory model.
// Parity checks are compiled in with BRAM_RDR_PARITY_EN.
module tb_bram_word_reader;
    import bram_rdr_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DP = DEF_DEPTH;
    localparam int WW = DEF_WORD_W;
    localparam int CW = DEF_CNT_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mem [DP];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bram_word_reader_if #(.ADDR_W(AW), .WORD_W(WW), .CNT_W(CW)) bus ();

    bram_word_reader #(
        .ADDR_W (AW),
        .DEPTH  (DP),
        .WORD_W (WW),
        .CNT_W  (CW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    // registered-read 1-bit memory
    always @(posedge clk) bus.mem_dout <= mem[bus.mem_raddr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a, input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < WW; j++)
            w[j] = mem[(a + k * WW + j) % DP];
        return w;
    endfunction

    // mode 0: ready held high, 1: random ready, 2: ready low for 30 cycles
    task automatic do_burst(input int a, input int n, input int mode);
        int          cyc;
        int          got;
        int          t_prev;
        int          sweep_err;
        logic [31:0] held;
        logic [31:0] ew;
        bit          seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(a);
        bus.req_words = CW'(n);
        bus.out_ready = (mode == 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("run_busy", 32'(bus.busy), 32'd1);
        chk("start_addr", 32'(bus.mem_raddr), 32'(a % DP));
        cyc = 0; got = 0; t_prev = 0; sweep_err = 0; seen = 0; held = '0;
        while (got < n && cyc < n * WW * 8 + 100) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = (cyc > 30);
            endcase
            if (mode == 0 && cyc < n * WW
                && 32'(bus.mem_raddr) != 32'((a + cyc) % DP))
                sweep_err++;
            if (mode == 2 && cyc <= 30 && bus.out_valid) begin
                if (!seen) begin
                    held = 32'(bus.out_data);
                    seen = 1;
                end else begin
                    chk("hold_data", 32'(bus.out_data), held);
                end
            end
            if (mode == 2 && cyc == 30 && n >= 2)
                chk("stall_addr", 32'(bus.mem_raddr), 32'((a + 2 * WW - 1) % DP));
            if (bus.out_valid && bus.out_ready) begin
                ew = exp_word(a, got);
                chk("data", 32'(bus.out_data), ew);
                chk("last", 32'(bus.out_last), 32'(got == n - 1));
`ifdef BRAM_RDR_PARITY_EN
                chk("parity", 32'(bus.out_parity), 32'(^ew));
`endif
                if (mode == 0)
                    chk("gap", 32'(cyc - t_prev), (got == 0) ? 32'(WW + 1) : 32'(WW));
                t_prev = cyc;
                got++;
            end
        end
        chk("word_count", 32'(got), 32'(n));
        if (mode == 0)
            chk("sweep", 32'(sweep_err), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_rdy", 32'(bus.req_ready), 32'd1);
        chk("end_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic do_abort(input int a, input int n, input int at);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(a);
        bus.req_words = CW'(n);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (at) @(negedge clk);
        chk("pre_busy", 32'(bus.busy), 32'd1);
        if (at > WW)
            chk("pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("abort_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_zero();
        int nv;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = AW'(77);
        bus.req_words = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("zero_rdy", 32'(bus.req_ready), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) nv++;
        end
        chk("zero_quiet", 32'(nv), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        for (int i = 0; i < DP; i++) mem[i] = 1'($urandom);
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_words = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 32'(bus.req_ready), 32'd1);
        chk("rst_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        pat = 8'hA5;
        for (int j = 0; j < 8; j++) mem[j] = pat[j];
        do_burst(0, 1, 0);
        do_burst(0, 4, 0);
        do_burst(DP - 4, 1, 0);
        do_burst(40, 3, 2);
        do_abort(200, 4, 5);
        do_burst(200, 2, 0);
        do_abort(300, 3, 12);
        do_burst(300, 3, 1);
        do_zero();

`ifdef BRAM_RDR_PARITY_EN
        pat = 8'h07;
        for (int j = 0; j < 8; j++) mem[500 + j] = pat[j];
        pat = 8'h03;
        for (int j = 0; j < 8; j++) mem[508 + j] = pat[j];
        do_burst(500, 2, 0);
`endif

        repeat (12)
            do_burst(int'($urandom_range(0, DP - 1)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 1)));
        do_burst(DP - 13, 5, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
